// File: rtl/pipeline_control_pkg.sv
// Shared types and defaults for the pipeline hazard controller and its forwarding helpers.
package pipeline_control_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    ERROR    = 2'b10
  } hazard_state_t;

  typedef enum logic [1:0] {
    FWD_REGFILE   = 2'b00,
    FWD_WRITEBACK = 2'b01,
    FWD_MEMORY    = 2'b10
  } forward_sel_t;

  localparam int unsigned DEFAULT_MEM_TIMEOUT = 16;

endpackage

// File: rtl/forwarding_select.sv
// Operand bypass selection for one decode source register; the memory stage wins over write-back.
module forwarding_select
  import pipeline_control_pkg::*;
(
  input  logic [4:0] source_reg,
  input  logic [4:0] mem_rd,
  input  logic       mem_write,
  input  logic [4:0] wb_rd,
  input  logic       wb_write,
  output logic [1:0] select
);

  always_comb begin
    select = FWD_REGFILE;
    if (mem_write && (mem_rd != 5'd0) && (mem_rd == source_reg)) begin
      select = FWD_MEMORY;
    end else if (wb_write && (wb_rd != 5'd0) && (wb_rd == source_reg)) begin
      select = FWD_WRITEBACK;
    end
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard control: memory-wait freeze with timeout, branch flush, load-use stall,
// operand forwarding and saturating performance counters.
module pipeline_hazard_controller
  import pipeline_control_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [4:0]             decodeRs1,
  input  logic [4:0]             decodeRs2,
  input  logic                   decodeUsesRs1,
  input  logic                   decodeUsesRs2,
  input  logic [4:0]             executeRd,
  input  logic                   executeMemoryRead,
  input  logic                   executeBranchTaken,
  input  logic [4:0]             memoryRd,
  input  logic                   memoryRegisterWrite,
  input  logic                   memoryAccess,
  input  logic                   memoryReady,
  input  logic [4:0]             writeBackRd,
  input  logic                   writeBackRegisterWrite,
  output logic                   pcWriteEnable,
  output logic                   fetchDecodeWriteEnable,
  output logic                   decodeExecuteWriteEnable,
  output logic                   executeMemoryWriteEnable,
  output logic                   fetchDecodeFlush,
  output logic                   decodeExecuteFlush,
  output logic                   memoryWriteBackBubble,
  output logic                   pcSelectJump,
  output logic [1:0]             forwardA,
  output logic [1:0]             forwardB,
  output logic                   hazardError,
  output logic [COUNT_WIDTH-1:0] stallCycles,
  output logic [COUNT_WIDTH-1:0] flushEvents,
  output logic [COUNT_WIDTH-1:0] freezeCycles
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

  hazard_state_t     state;
  hazard_state_t     state_eff;
  logic [WAIT_W-1:0] wait_count;
  logic              frozen;
  logic              branch_flush;
  logic              load_use;
  logic              rs_match;

  // Outputs are decoded as if already in RUN during the reset cycle.
  always_comb state_eff = reset ? RUN : state;

  always_comb begin
    frozen = 1'b0;
    case (state_eff)
      RUN:      frozen = memoryAccess && !memoryReady;
      MEM_WAIT: frozen = !memoryReady;
      ERROR:    frozen = 1'b1;
      default:  frozen = 1'b0;
    endcase
  end

  always_comb begin
    rs_match = ((executeRd == decodeRs1) && decodeUsesRs1) ||
               ((executeRd == decodeRs2) && decodeUsesRs2);
    branch_flush = !frozen && executeBranchTaken;
    load_use     = !frozen && !executeBranchTaken && executeMemoryRead &&
                   (executeRd != 5'd0) && rs_match;
  end

  always_comb begin
    pcWriteEnable            = 1'b1;
    fetchDecodeWriteEnable   = 1'b1;
    decodeExecuteWriteEnable = 1'b1;
    executeMemoryWriteEnable = 1'b1;
    fetchDecodeFlush         = 1'b0;
    decodeExecuteFlush       = 1'b0;
    memoryWriteBackBubble    = 1'b0;
    pcSelectJump             = 1'b0;
    if (frozen) begin
      pcWriteEnable            = 1'b0;
      fetchDecodeWriteEnable   = 1'b0;
      decodeExecuteWriteEnable = 1'b0;
      executeMemoryWriteEnable = 1'b0;
      memoryWriteBackBubble    = 1'b1;
    end else if (branch_flush) begin
      pcSelectJump       = 1'b1;
      fetchDecodeFlush   = 1'b1;
      decodeExecuteFlush = 1'b1;
    end else if (load_use) begin
      pcWriteEnable          = 1'b0;
      fetchDecodeWriteEnable = 1'b0;
      decodeExecuteFlush     = 1'b1;
    end
  end

  always_comb hazardError = (state_eff == ERROR);

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= RUN;
      wait_count   <= '0;
      stallCycles  <= '0;
      flushEvents  <= '0;
      freezeCycles <= '0;
    end else begin
      case (state)
        RUN: begin
          if (memoryAccess && !memoryReady) begin
            state      <= MEM_WAIT;
            wait_count <= WAIT_W'(1);
          end
        end
        MEM_WAIT: begin
          if (memoryReady) begin
            state      <= RUN;
            wait_count <= '0;
          end else if (wait_count == WAIT_W'(MEM_TIMEOUT)) begin
            state <= ERROR;
          end else begin
            wait_count <= wait_count + WAIT_W'(1);
          end
        end
        ERROR:   state <= ERROR;
        default: state <= RUN;
      endcase
      if (load_use && (stallCycles != '1))
        stallCycles <= stallCycles + COUNT_WIDTH'(1);
      if (branch_flush && (flushEvents != '1))
        flushEvents <= flushEvents + COUNT_WIDTH'(1);
      if (frozen && (freezeCycles != '1))
        freezeCycles <= freezeCycles + COUNT_WIDTH'(1);
    end
  end

  forwarding_select u_forward_a (
    .source_reg (decodeRs1),
    .mem_rd     (memoryRd),
    .mem_write  (memoryRegisterWrite),
    .wb_rd      (writeBackRd),
    .wb_write   (writeBackRegisterWrite),
    .select     (forwardA)
  );

  forwarding_select u_forward_b (
    .source_reg (decodeRs2),
    .mem_rd     (memoryRd),
    .mem_write  (memoryRegisterWrite),
    .wb_rd      (writeBackRd),
    .wb_write   (writeBackRegisterWrite),
    .select     (forwardB)
  );

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: directed scenarios plus randomized traffic against a reference model.
module tb_pipeline_hazard_controller;

  localparam int unsigned TO   = 16;
  localparam int unsigned CW   = 4;
  localparam int          CMAX = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset;
  logic [4:0]    decodeRs1, decodeRs2, executeRd, memoryRd, writeBackRd;
  logic          decodeUsesRs1, decodeUsesRs2, executeMemoryRead, executeBranchTaken;
  logic          memoryRegisterWrite, memoryAccess, memoryReady, writeBackRegisterWrite;
  logic          pcWriteEnable, fetchDecodeWriteEnable, decodeExecuteWriteEnable, executeMemoryWriteEnable;
  logic          fetchDecodeFlush, decodeExecuteFlush, memoryWriteBackBubble, pcSelectJump;
  logic [1:0]    forwardA, forwardB;
  logic          hazardError;
  logic [CW-1:0] stallCycles, flushEvents, freezeCycles;

  pipeline_hazard_controller #(.MEM_TIMEOUT(TO), .COUNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset),
    .decodeRs1(decodeRs1), .decodeRs2(decodeRs2),
    .decodeUsesRs1(decodeUsesRs1), .decodeUsesRs2(decodeUsesRs2),
    .executeRd(executeRd), .executeMemoryRead(executeMemoryRead),
    .executeBranchTaken(executeBranchTaken),
    .memoryRd(memoryRd), .memoryRegisterWrite(memoryRegisterWrite),
    .memoryAccess(memoryAccess), .memoryReady(memoryReady),
    .writeBackRd(writeBackRd), .writeBackRegisterWrite(writeBackRegisterWrite),
    .pcWriteEnable(pcWriteEnable), .fetchDecodeWriteEnable(fetchDecodeWriteEnable),
    .decodeExecuteWriteEnable(decodeExecuteWriteEnable),
    .executeMemoryWriteEnable(executeMemoryWriteEnable),
    .fetchDecodeFlush(fetchDecodeFlush), .decodeExecuteFlush(decodeExecuteFlush),
    .memoryWriteBackBubble(memoryWriteBackBubble), .pcSelectJump(pcSelectJump),
    .forwardA(forwardA), .forwardB(forwardB), .hazardError(hazardError),
    .stallCycles(stallCycles), .flushEvents(flushEvents), .freezeCycles(freezeCycles)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: an outstanding access, how long it has waited, and a sticky timeout.
  bit m_pending = 0;
  int m_waited  = 0;
  bit m_err     = 0;
  int m_stall_cnt = 0, m_flush_cnt = 0, m_freeze_cnt = 0;
  bit m_frozen, m_branch, m_stall;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int fwd_ref(input logic [4:0] src);
    if (memoryRegisterWrite && memoryRd != 0 && memoryRd == src) return 2;
    if (writeBackRegisterWrite && writeBackRd != 0 && writeBackRd == src) return 1;
    return 0;
  endfunction

  task automatic compare_all();
    bit err_now, pend_now, hit;
    err_now  = m_err && !reset;
    pend_now = m_pending && !reset;
    m_frozen = err_now || ((pend_now || memoryAccess) && !memoryReady);
    m_branch = !m_frozen && executeBranchTaken;
    hit      = (executeRd == decodeRs1 && decodeUsesRs1) || (executeRd == decodeRs2 && decodeUsesRs2);
    m_stall  = !m_frozen && !m_branch && executeMemoryRead && executeRd != 0 && hit;
    chk("pcWriteEnable", pcWriteEnable, int'(!m_frozen && !m_stall));
    chk("fetchDecodeWriteEnable", fetchDecodeWriteEnable, int'(!m_frozen && !m_stall));
    chk("decodeExecuteWriteEnable", decodeExecuteWriteEnable, int'(!m_frozen));
    chk("executeMemoryWriteEnable", executeMemoryWriteEnable, int'(!m_frozen));
    chk("fetchDecodeFlush", fetchDecodeFlush, int'(m_branch));
    chk("decodeExecuteFlush", decodeExecuteFlush, int'(m_branch || m_stall));
    chk("memoryWriteBackBubble", memoryWriteBackBubble, int'(m_frozen));
    chk("pcSelectJump", pcSelectJump, int'(m_branch));
    chk("forwardA", forwardA, fwd_ref(decodeRs1));
    chk("forwardB", forwardB, fwd_ref(decodeRs2));
    chk("hazardError", hazardError, int'(err_now));
    chk("stallCycles", stallCycles, m_stall_cnt);
    chk("flushEvents", flushEvents, m_flush_cnt);
    chk("freezeCycles", freezeCycles, m_freeze_cnt);
  endtask

  task automatic model_advance();
    if (reset) begin
      m_pending = 0; m_waited = 0; m_err = 0;
      m_stall_cnt = 0; m_flush_cnt = 0; m_freeze_cnt = 0;
    end else begin
      if (m_stall)  m_stall_cnt  = (m_stall_cnt  < CMAX) ? m_stall_cnt  + 1 : CMAX;
      if (m_branch) m_flush_cnt  = (m_flush_cnt  < CMAX) ? m_flush_cnt  + 1 : CMAX;
      if (m_frozen) m_freeze_cnt = (m_freeze_cnt < CMAX) ? m_freeze_cnt + 1 : CMAX;
      if (!m_err && (m_pending || memoryAccess)) begin
        if (!memoryReady) begin
          m_waited++;
          m_pending = 1;
          if (m_waited > int'(TO)) m_err = 1;
        end else begin
          m_pending = 0;
          m_waited  = 0;
        end
      end
    end
  endtask

  task automatic at_neg();
    @(negedge clock);
    compare_all();
  endtask

  task automatic finish_cycle();
    @(posedge clock);
    model_advance();
    #1;
  endtask

  task automatic idle_inputs();
    decodeRs1 = 0; decodeRs2 = 0; decodeUsesRs1 = 0; decodeUsesRs2 = 0;
    executeRd = 0; executeMemoryRead = 0; executeBranchTaken = 0;
    memoryRd = 0; memoryRegisterWrite = 0; memoryAccess = 0; memoryReady = 1;
    writeBackRd = 0; writeBackRegisterWrite = 0;
  endtask

  task automatic do_reset();
    reset = 1; idle_inputs();
    at_neg(); finish_cycle();
    reset = 0;
  endtask

  int first_err;
  int low_hold;

  initial begin
    reset = 1; idle_inputs();
    do_reset();
    at_neg();
    chk("reset_stallCycles", stallCycles, 0);
    chk("reset_hazardError", hazardError, 0);
    finish_cycle();

    // Load-use on rs1 for one cycle.
    executeMemoryRead = 1; executeRd = 5; decodeRs1 = 5; decodeUsesRs1 = 1;
    at_neg();
    chk("lu_pcWriteEnable", pcWriteEnable, 0);
    chk("lu_decodeExecuteFlush", decodeExecuteFlush, 1);
    finish_cycle();
    idle_inputs();
    at_neg();
    chk("lu_stallCycles", stallCycles, 1);
    finish_cycle();

    // x0 destination never stalls.
    executeMemoryRead = 1; executeRd = 0; decodeRs1 = 0; decodeUsesRs1 = 1;
    at_neg();
    chk("x0_pcWriteEnable", pcWriteEnable, 1);
    finish_cycle();
    idle_inputs();

    // Three not-ready cycles, then ready.
    do_reset();
    memoryAccess = 1; memoryReady = 0;
    for (int i = 0; i < 3; i++) begin
      at_neg();
      chk("wait_bubble", memoryWriteBackBubble, 1);
      finish_cycle();
    end
    memoryReady = 1;
    at_neg();
    chk("ready_unfrozen", executeMemoryWriteEnable, 1);
    finish_cycle();
    idle_inputs();
    at_neg();
    chk("wait_freezeCycles", freezeCycles, 3);
    finish_cycle();

    // Timeout: ready held low until the sticky error appears.
    do_reset();
    memoryAccess = 1; memoryReady = 0;
    first_err = -1;
    for (int i = 0; i < 40; i++) begin
      at_neg();
      if (hazardError && first_err < 0) first_err = i;
      finish_cycle();
    end
    at_neg();
    chk("timeout_first_cycle", first_err, 17);
    chk("timeout_held", hazardError, 1);
    chk("timeout_freeze_saturated", freezeCycles, CMAX);
    finish_cycle();
    reset = 1;
    at_neg();
    chk("reset_in_error_flag", hazardError, 0);
    finish_cycle();
    reset = 0; idle_inputs();
    at_neg();
    chk("after_error_flag", hazardError, 0);
    chk("after_error_bubble", memoryWriteBackBubble, 0);
    finish_cycle();

    // Branch arriving during a memory wait takes effect on the ready cycle.
    do_reset();
    memoryAccess = 1; memoryReady = 0; executeBranchTaken = 1;
    for (int i = 0; i < 2; i++) begin
      at_neg();
      chk("br_frozen_jump", pcSelectJump, 0);
      finish_cycle();
    end
    memoryReady = 1;
    at_neg();
    chk("br_ready_jump", pcSelectJump, 1);
    chk("br_ready_fdflush", fetchDecodeFlush, 1);
    finish_cycle();
    idle_inputs();
    at_neg();
    chk("br_flushEvents", flushEvents, 1);
    finish_cycle();

    // Forwarding priority.
    memoryRd = 7; writeBackRd = 7; memoryRegisterWrite = 1; writeBackRegisterWrite = 1; decodeRs2 = 7;
    at_neg();
    chk("fwdB_memory", forwardB, 2);
    finish_cycle();
    memoryRegisterWrite = 0;
    at_neg();
    chk("fwdB_writeback", forwardB, 1);
    finish_cycle();
    idle_inputs();

    // Randomized traffic.
    low_hold = 0;
    for (int c = 0; c < 2500; c++) begin
      reset = ($urandom_range(0, 149) == 0);
      decodeRs1 = 5'($urandom_range(0, 7));
      decodeRs2 = 5'($urandom_range(0, 7));
      decodeUsesRs1 = 1'($urandom);
      decodeUsesRs2 = 1'($urandom);
      executeRd = 5'($urandom_range(0, 7));
      executeMemoryRead = ($urandom_range(0, 2) == 0);
      executeBranchTaken = ($urandom_range(0, 5) == 0);
      memoryRd = 5'($urandom_range(0, 7));
      memoryRegisterWrite = 1'($urandom);
      writeBackRd = 5'($urandom_range(0, 7));
      writeBackRegisterWrite = 1'($urandom);
      memoryAccess = ($urandom_range(0, 3) == 0);
      if (low_hold == 0 && $urandom_range(0, 299) == 0) low_hold = $urandom_range(14, 22);
      if (low_hold > 0) begin
        memoryReady = 0;
        low_hold--;
      end else begin
        memoryReady = ($urandom_range(0, 3) != 0);
      end
      at_neg();
      finish_cycle();
    end
    reset = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
